// File: rtl/stopwatch_pkg.sv
// Status encodings and command types shared with the stopwatch control FSM.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_START = 2'd1,
    CMD_STOP  = 2'd2,
    CMD_RESET = 2'd3
  } cmd_e;

  // Status 2'b11 is corrupt, so no command is accepted there.
  function automatic logic cmd_legal(input cmd_e cmd, input logic [1:0] status);
    logic ok;
    ok = 1'b0;
    case (cmd)
      CMD_START: ok = (status == ST_IDLE) || (status == ST_PAUSED);
      CMD_STOP:  ok = (status == ST_RUNNING);
      CMD_RESET: ok = (status == ST_RUNNING) || (status == ST_PAUSED);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/stopwatch_cmd_gen_if.sv
// Button inputs, status feedback and command pulses between board and control FSM.
interface stopwatch_cmd_gen_if;
  logic       btn_start_raw;
  logic       btn_stop_raw;
  logic       btn_reset_raw;
  logic [1:0] status_in;
  logic       start;
  logic       stop;
  logic       reset;
  logic       cmd_reject;

  modport master (
    output btn_start_raw, btn_stop_raw, btn_reset_raw, status_in,
    input  start, stop, reset, cmd_reject
  );

  modport slave (
    input  btn_start_raw, btn_stop_raw, btn_reset_raw, status_in,
    output start, stop, reset, cmd_reject
  );
endinterface

// File: rtl/button_debouncer.sv
// Synchronises one raw button, debounces it and emits a one-cycle pulse per press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic RELEASED_RAW = ACTIVE_LOW;

  logic          sync1_q, sync2_q;
  logic          pressed;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          prev_q;

  assign pressed = sync2_q ^ ACTIVE_LOW;

  // Flip on the cycle that would bring the count to DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (pressed != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = pressed;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RELEASED_RAW;
      sync2_q <= RELEASED_RAW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign level       = level_q;
  assign press_pulse = level_q & ~prev_q;

endmodule

// File: rtl/stopwatch_cmd_gen.sv
// Turns three debounced buttons into arbitrated, status-filtered command pulses.
module stopwatch_cmd_gen
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW_BTN  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  stopwatch_cmd_gen_if.slave   bus
);

  logic lvl_start, lvl_stop, lvl_reset;
  logic ev_start, ev_stop, ev_reset;
  cmd_e winner;
  logic lost, legal;
  logic start_d, stop_d, reset_d, reject_d;
  logic start_q, stop_q, reset_q, reject_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW_BTN)) u_db_start (
    .clk(clk), .rst(rst), .raw(bus.btn_start_raw), .level(lvl_start), .press_pulse(ev_start)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW_BTN)) u_db_stop (
    .clk(clk), .rst(rst), .raw(bus.btn_stop_raw), .level(lvl_stop), .press_pulse(ev_stop)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW_BTN)) u_db_reset (
    .clk(clk), .rst(rst), .raw(bus.btn_reset_raw), .level(lvl_reset), .press_pulse(ev_reset)
  );

  // Losers are dropped outright; the rejection pulse is the only trace they leave.
  always_comb begin
    winner = CMD_NONE;
    lost   = 1'b0;
    if (ev_reset) begin
      winner = CMD_RESET;
      lost   = ev_stop | ev_start;
    end else if (ev_stop) begin
      winner = CMD_STOP;
      lost   = ev_start;
    end else if (ev_start) begin
      winner = CMD_START;
    end
    legal    = cmd_legal(winner, bus.status_in);
    start_d  = legal && (winner == CMD_START);
    stop_d   = legal && (winner == CMD_STOP);
    reset_d  = legal && (winner == CMD_RESET);
    reject_d = ((winner != CMD_NONE) && !legal) || lost;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      reset_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      start_q  <= start_d;
      stop_q   <= stop_d;
      reset_q  <= reset_d;
      reject_q <= reject_d;
    end
  end

  assign bus.start      = start_q;
  assign bus.stop       = stop_q;
  assign bus.reset      = reset_q;
  assign bus.cmd_reject = reject_q;

  logic unused_levels;
  assign unused_levels = lvl_start ^ lvl_stop ^ lvl_reset;

endmodule
